// File: rtl/sat_round_pkg.sv
// rtl/sat_round_pkg.sv - shared constants and helpers for the sat_round_pipe requantiser
//
// Purpose: rounding-mode encoding, saturation-limit helpers and the
//          parameter legality check shared by the requantiser files.
// Ports:   none (package).
package sat_round_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC   = 2'b00,
    RND_HALF_UP = 2'b01,
    RND_RNE     = 2'b10,
    RND_TRUNC_B = 2'b11   // second encoding of truncate
  } rnd_mode_e;

  // Largest positive value of an nb-bit two's-complement word.
  function automatic longint sat_max_val(input int nb);
    return (64'sd1 <<< (nb - 1)) - 64'sd1;
  endfunction

  // Most negative value of an nb-bit two's-complement word.
  function automatic longint sat_min_val(input int nb);
    return -(64'sd1 <<< (nb - 1));
  endfunction

  // At least two dropped fraction bits (half and sticky bits exist) and
  // no more integer bits at the output than at the input.
  function automatic bit params_legal(input int nb_in, input int nbf_in,
                                      input int nb_out, input int nbf_out);
    return ((nbf_in - nbf_out) >= 2) && ((nb_out - nbf_out) <= (nb_in - nbf_in));
  endfunction

endpackage

// File: rtl/sat_round_pipe_if.sv
// rtl/sat_round_pipe_if.sv - stream and statistics bundle of the sat_round_pipe requantiser
//
// Purpose: groups the sample stream, handshake, mode and statistics signals.
// Signals: i_data/i_valid/i_mode/o_in_ready   input beat and its handshake
//          o_data/o_valid/o_sat_flag/i_ready  output beat and its handshake
//          i_clr_sat, o_sat_sticky, o_sat_cnt  saturation statistics
// Modports: master drives the i_* side (source/sink logic), slave is the block.
interface sat_round_pipe_if
  import sat_round_pkg::*;
#(
  parameter int NB_DATA_IN  = 50,
  parameter int NB_DATA_OUT = 16,
  parameter int NCH         = 2,
  parameter int NB_CNT      = 16
);

  logic [NCH*NB_DATA_IN-1:0]  i_data;
  logic                       i_valid;
  logic                       o_in_ready;
  logic [1:0]                 i_mode;
  logic                       i_ready;
  logic                       i_clr_sat;
  logic [NCH*NB_DATA_OUT-1:0] o_data;
  logic                       o_valid;
  logic [NCH-1:0]             o_sat_flag;
  logic [NCH-1:0]             o_sat_sticky;
  logic [NB_CNT-1:0]          o_sat_cnt;

  modport master (
    output i_data, i_valid, i_mode, i_ready, i_clr_sat,
    input  o_in_ready, o_data, o_valid, o_sat_flag, o_sat_sticky, o_sat_cnt
  );

  modport slave (
    input  i_data, i_valid, i_mode, i_ready, i_clr_sat,
    output o_in_ready, o_data, o_valid, o_sat_flag, o_sat_sticky, o_sat_cnt
  );

endinterface

// File: rtl/sat_round_lane.sv
// rtl/sat_round_lane.sv - single-channel round and saturate logic
//
// Purpose: combinational requantisation of one channel, split in two halves
//          so the top can register between them.
// Ports:   din_i   signed input sample (NB_IN bits)
//          mode_i  rounding mode
//          r_o     rounded value, NB_IN+1-D bits (feeds the stage-1 register)
//          r_i     registered rounded value
//          dout_o  saturated output sample (NB_OUT bits)
//          sat_o   1 when r_i was clamped
module sat_round_lane
  import sat_round_pkg::*;
#(
  parameter int NB_IN   = 50,
  parameter int NBF_IN  = 45,
  parameter int NB_OUT  = 16,
  parameter int NBF_OUT = 15
) (
  input  logic [NB_IN-1:0]                   din_i,
  input  logic [1:0]                         mode_i,
  output logic [NB_IN-(NBF_IN-NBF_OUT):0]    r_o,
  input  logic [NB_IN-(NBF_IN-NBF_OUT):0]    r_i,
  output logic [NB_OUT-1:0]                  dout_o,
  output logic                               sat_o
);

  localparam int D    = NBF_IN - NBF_OUT;
  localparam int NB_R = NB_IN + 1 - D;
  localparam logic [NB_OUT-1:0] SAT_MAX = NB_OUT'(sat_max_val(NB_OUT));
  localparam logic [NB_OUT-1:0] SAT_MIN = NB_OUT'(sat_min_val(NB_OUT));

  logic [NB_IN:0]       ext;
  logic [NB_R-1:0]      floor_v;
  logic                 half_bit;
  logic                 sticky_bits;
  logic                 lsb_bit;
  logic                 inc;
  logic [NB_R-NB_OUT:0] r_top;
  logic                 in_range;

  // Round half. The extra sign bit guarantees floor_v + 1 cannot wrap.
  always_comb begin
    ext         = {din_i[NB_IN-1], din_i};
    floor_v     = ext[NB_IN:D];
    half_bit    = ext[D-1];
    sticky_bits = |ext[D-2:0];
    lsb_bit     = ext[D];
    inc         = 1'b0;
    case (mode_i)
      RND_HALF_UP: inc = half_bit;
      RND_RNE:     inc = half_bit & (sticky_bits | lsb_bit);
      default:     inc = 1'b0;
    endcase
    r_o = floor_v + NB_R'(inc);
  end

  // Saturate half. r_i fits the output iff all bits from the output sign
  // position upward agree; otherwise clamp toward the sign of r_i.
  always_comb begin
    r_top    = r_i[NB_R-1:NB_OUT-1];
    in_range = (&r_top) | ~(|r_top);
    sat_o    = ~in_range;
    if (in_range) begin
      dout_o = r_i[NB_OUT-1:0];
    end else if (r_i[NB_R-1]) begin
      dout_o = SAT_MIN;
    end else begin
      dout_o = SAT_MAX;
    end
  end

endmodule

// File: rtl/sat_round_pipe.sv
// rtl/sat_round_pipe.sv - two-stage multi-channel round/saturate requantiser
//
// Purpose: converts NCH signed Qm.n samples to a narrower signed format with
//          selectable rounding, saturation flags and saturation statistics.
// Ports:   i_clk  clock
//          i_rst  asynchronous active-high reset
//          bus    sat_round_pipe_if.slave: input beat (i_data, i_valid, i_mode,
//                 o_in_ready), output beat (o_data, o_valid, o_sat_flag,
//                 i_ready) and statistics (i_clr_sat, o_sat_sticky, o_sat_cnt)
module sat_round_pipe
  import sat_round_pkg::*;
#(
  parameter int NB_DATA_IN   = 50,
  parameter int NBF_DATA_IN  = 45,
  parameter int NB_DATA_OUT  = 16,
  parameter int NBF_DATA_OUT = 15,
  parameter int NCH          = 2,
  parameter int NB_CNT       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sat_round_pipe_if.slave  bus
);

  localparam int D    = NBF_DATA_IN - NBF_DATA_OUT;
  localparam int NB_R = NB_DATA_IN + 1 - D;
  localparam logic [NB_CNT-1:0] CNT_MAX = '1;

  if (!params_legal(NB_DATA_IN, NBF_DATA_IN, NB_DATA_OUT, NBF_DATA_OUT)) begin : g_illegal_params
    $error("sat_round_pipe: illegal NB/NBF parameter set");
  end

  // Stage 1: rounded values and their valid bit.
  logic [NCH*NB_R-1:0]        r_d;
  logic [NCH*NB_R-1:0]        r_q;
  logic                       v1_q;

  // Stage 2: registered outputs.
  logic [NCH*NB_DATA_OUT-1:0] data_d;
  logic [NCH*NB_DATA_OUT-1:0] data_q;
  logic [NCH-1:0]             flag_d;
  logic [NCH-1:0]             flag_q;
  logic                       out_valid_q;

  // Statistics.
  logic [NCH-1:0]             sticky_d;
  logic [NCH-1:0]             sticky_q;
  logic [NB_CNT-1:0]          cnt_d;
  logic [NB_CNT-1:0]          cnt_q;

  logic                       adv;
  logic                       out_hs;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    sat_round_lane #(
      .NB_IN   (NB_DATA_IN),
      .NBF_IN  (NBF_DATA_IN),
      .NB_OUT  (NB_DATA_OUT),
      .NBF_OUT (NBF_DATA_OUT)
    ) u_lane (
      .din_i  (bus.i_data[k*NB_DATA_IN +: NB_DATA_IN]),
      .mode_i (bus.i_mode),
      .r_o    (r_d[k*NB_R +: NB_R]),
      .r_i    (r_q[k*NB_R +: NB_R]),
      .dout_o (data_d[k*NB_DATA_OUT +: NB_DATA_OUT]),
      .sat_o  (flag_d[k])
    );
  end

  // One global enable: the whole pipe moves whenever the output slot is
  // empty or being taken, so bubbles are carried rather than squeezed out.
  assign adv    = ~out_valid_q | bus.i_ready;
  assign out_hs = out_valid_q & bus.i_ready;

  // Clear has priority, so a beat leaving in the clear cycle is not counted.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (bus.i_clr_sat) begin
      sticky_d = '0;
      cnt_d    = '0;
    end else if (out_hs) begin
      sticky_d = sticky_q | flag_q;
      if ((|flag_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q         <= '0;
      v1_q        <= 1'b0;
      data_q      <= '0;
      flag_q      <= '0;
      out_valid_q <= 1'b0;
      sticky_q    <= '0;
      cnt_q       <= '0;
    end else begin
      if (adv) begin
        r_q         <= r_d;
        v1_q        <= bus.i_valid;
        data_q      <= data_d;
        flag_q      <= flag_d;
        out_valid_q <= v1_q;
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_in_ready   = adv;
  assign bus.o_data       = data_q;
  assign bus.o_valid      = out_valid_q;
  assign bus.o_sat_flag   = flag_q;
  assign bus.o_sat_sticky = sticky_q;
  assign bus.o_sat_cnt    = cnt_q;

endmodule

// File: tb/tb_sat_round_pipe.sv
// tb/tb_sat_round_pipe.sv - self-checking bench for sat_round_pipe
module tb_sat_round_pipe;
  import sat_round_pkg::*;

  localparam int NB_IN   = 8;
  localparam int NBF_IN  = 4;
  localparam int NB_OUT  = 4;
  localparam int NBF_OUT = 2;
  localparam int NCH     = 2;
  localparam int NB_CNT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sat_round_pipe_if #(
    .NB_DATA_IN  (NB_IN),
    .NB_DATA_OUT (NB_OUT),
    .NCH         (NCH),
    .NB_CNT      (NB_CNT)
  ) bus ();

  sat_round_pipe #(
    .NB_DATA_IN   (NB_IN),
    .NBF_DATA_IN  (NBF_IN),
    .NB_DATA_OUT  (NB_OUT),
    .NBF_DATA_OUT (NBF_OUT),
    .NCH          (NCH),
    .NB_CNT       (NB_CNT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic [4:0] e0;
  logic [4:0] e1;
  logic [1:0] m_sticky;
  int         m_cnt;
  logic       rv, rr, rc;
  logic [7:0] rd0, rd1;
  logic [1:0] rm;
  logic       hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: value/4 rounded by the selected rule, then clamped to 4-bit signed.
  // Returns {flag, result[3:0]}.
  function automatic logic [4:0] ref_q(input logic [7:0] x, input logic [1:0] m);
    int xv, fl, rem, up, v;
    xv  = int'($signed(x));
    fl  = (xv >= 0) ? (xv / 4) : -((3 - xv) / 4);
    rem = xv - 4 * fl;
    up  = 0;
    if (m == 2'd1) up = (rem >= 2) ? 1 : 0;
    if (m == 2'd2) up = ((rem > 2) || ((rem == 2) && ((fl & 1) != 0))) ? 1 : 0;
    v = fl + up;
    if (v > 7)  return {1'b1, 4'h7};
    if (v < -8) return {1'b1, 4'h8};
    return {1'b0, v[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] m, input logic rdy);
    bus.i_valid = v;
    bus.i_data  = {d1, d0};
    bus.i_mode  = m;
    bus.i_ready = rdy;
    #1;
  endtask

  // Single beat into an empty pipe; result must appear exactly two edges later.
  task automatic check_beat(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [1:0] m, input int exp_data, input int exp_flag);
    drive(1'b1, d0, d1, m, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    #1;
    chk({tag, "_lat1"}, 32'(bus.o_valid), 0);
    tick();
    chk({tag, "_valid"}, 32'(bus.o_valid), 1);
    chk({tag, "_data"}, 32'(bus.o_data), exp_data);
    chk({tag, "_flag"}, 32'(bus.o_sat_flag), exp_flag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.i_clr_sat = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);

    // Reset state
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data", 32'(bus.o_data), 0);
    chk("rst_cnt", 32'(bus.o_sat_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_inrdy", 32'(bus.o_in_ready), 1);
    chk("rst_sticky", 32'(bus.o_sat_sticky), 0);
    chk("rst_flag", 32'(bus.o_sat_flag), 0);

    // Mode sweep on 0.625
    check_beat("sweep_trunc", 8'h0A, 8'h00, 2'd0, 'h02, 0);
    check_beat("sweep_hup",   8'h0A, 8'h00, 2'd1, 'h03, 0);
    check_beat("sweep_rne",   8'h0A, 8'h00, 2'd2, 'h02, 0);
    check_beat("sweep_m11",   8'h0A, 8'h00, 2'd3, 'h02, 0);

    // Ties
    check_beat("tie_rne",   8'h0E, 8'hF6, 2'd2, 'hE4, 0);
    check_beat("tie_hup",   8'hF6, 8'h0E, 2'd1, 'h4E, 0);
    check_beat("tie_trunc", 8'hF6, 8'h0A, 2'd0, 'h2D, 0);

    // Saturation
    check_beat("sat_extremes", 8'h7F, 8'h80, 2'd0, 'h87, 'h3);
    check_beat("sat_1e_trunc", 8'h1E, 8'h80, 2'd0, 'h87, 'h2);
    check_beat("sat_1e_hup",   8'h1E, 8'h80, 2'd1, 'h87, 'h3);

    // Statistics: clear, then four saturating beats on ch0
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    bus.i_clr_sat = 1'b1;
    tick();
    bus.i_clr_sat = 1'b0;
    chk("stat_clr_cnt", 32'(bus.o_sat_cnt), 0);
    chk("stat_clr_sticky", 32'(bus.o_sat_sticky), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h7F, 8'h00, 2'd0, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    tick();
    tick();
    chk("stat_cnt_held", 32'(bus.o_sat_cnt), 3);
    chk("stat_sticky", 32'(bus.o_sat_sticky), 'h1);
    chk("stat_drained", 32'(bus.o_valid), 0);

    // Clear coincident with a saturating handshake
    drive(1'b1, 8'h7F, 8'h00, 2'd0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    tick();
    chk("clr_hs_valid", 32'(bus.o_valid), 1);
    chk("clr_hs_flag", 32'(bus.o_sat_flag), 'h1);
    bus.i_clr_sat = 1'b1;
    tick();
    bus.i_clr_sat = 1'b0;
    chk("clr_hs_cnt", 32'(bus.o_sat_cnt), 0);
    chk("clr_hs_sticky", 32'(bus.o_sat_sticky), 0);

    // Backpressure: A at output, B in stage 1, C offered during the stall
    drive(1'b1, 8'h10, 8'h04, 2'd0, 1'b1);
    tick();
    drive(1'b1, 8'h08, 8'hFC, 2'd0, 1'b1);
    tick();
    drive(1'b1, 8'hF0, 8'h14, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(bus.o_valid), 1);
      chk("bp_inrdy", 32'(bus.o_in_ready), 0);
      chk("bp_data_a", 32'(bus.o_data), 'h14);
      tick();
    end
    bus.i_ready = 1'b1;
    #1;
    chk("bp_rel_inrdy", 32'(bus.o_in_ready), 1);
    chk("bp_rel_a", 32'(bus.o_data), 'h14);
    tick();
    bus.i_valid = 1'b0;
    #1;
    chk("bp_b_valid", 32'(bus.o_valid), 1);
    chk("bp_b", 32'(bus.o_data), 'hF2);
    tick();
    chk("bp_c_valid", 32'(bus.o_valid), 1);
    chk("bp_c", 32'(bus.o_data), 'h5C);
    tick();
    chk("bp_empty", 32'(bus.o_valid), 0);

    // Reset with beats in both stages
    drive(1'b1, 8'h7F, 8'h00, 2'd0, 1'b1);
    tick();
    drive(1'b1, 8'h08, 8'h00, 2'd0, 1'b1);
    tick();
    drive(1'b1, 8'h10, 8'h00, 2'd0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
    chk("mid_pre_valid", 32'(bus.o_valid), 1);
    chk("mid_pre_sticky", 32'(bus.o_sat_sticky), 'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 0);
    chk("mid_rst_data", 32'(bus.o_data), 0);
    chk("mid_rst_flag", 32'(bus.o_sat_flag), 0);
    chk("mid_rst_sticky", 32'(bus.o_sat_sticky), 0);
    chk("mid_rst_cnt", 32'(bus.o_sat_cnt), 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_inrdy", 32'(bus.o_in_ready), 1);
    tick();
    chk("mid_rst_flushed", 32'(bus.o_valid), 0);
    check_beat("mid_rst_next", 8'h0A, 8'h0E, 2'd1, 'h43, 0);

    // Randomised traffic against the reference model and a scoreboard
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
    bus.i_clr_sat = 1'b1;
    tick();
    bus.i_clr_sat = 1'b0;
    exp_q.delete();
    m_sticky = 2'b00;
    m_cnt    = 0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        rv  = ($urandom_range(0, 9) < 7);
        rr  = ($urandom_range(0, 9) < 7);
        rc  = ($urandom_range(0, 19) == 0);
      end else begin
        rv  = 1'b0;
        rr  = 1'b1;
        rc  = 1'b0;
      end
      rd0 = 8'($urandom);
      rd1 = 8'($urandom);
      rm  = 2'($urandom_range(0, 3));
      bus.i_clr_sat = rc;
      drive(rv, rd0, rd1, rm, rr);
      chk("rnd_sticky", 32'(bus.o_sat_sticky), 32'(m_sticky));
      chk("rnd_cnt", 32'(bus.o_sat_cnt), 32'(m_cnt));
      hs = bus.o_valid & rr;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_beat", 32'(bus.o_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_data", 32'(bus.o_data), 32'(e[7:0]));
          chk("rnd_flag", 32'(bus.o_sat_flag), 32'(e[9:8]));
          if (!rc) begin
            m_sticky = m_sticky | e[9:8];
            if ((e[9:8] != 2'b00) && (m_cnt < 3)) m_cnt++;
          end
        end
      end
      if (rc) begin
        m_sticky = 2'b00;
        m_cnt    = 0;
      end
      if (rv && bus.o_in_ready) begin
        e0 = ref_q(rd0, rm);
        e1 = ref_q(rd1, rm);
        exp_q.push_back({e1[4], e0[4], e1[3:0], e0[3:0]});
      end
      tick();
    end
    bus.i_clr_sat = 1'b0;
    chk("rnd_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sat_round_pipe.md
# sat_round_pipe

Pipelined, multi-channel fixed-point requantiser for the IIR datapath: converts NCH signed Qm.n samples to a narrower signed format. Rounding is run-time selectable: truncate, round-half-up or round-to-nearest-even. Saturation is overflow-safe, and the block keeps per-channel sticky saturation flags and a saturating event counter. It sits between the filter accumulator and the output register stage, with a valid/ready handshake so downstream logic can stall it.

## Interface
- NB_DATA_IN, 50, input word width per channel
- NBF_DATA_IN, 45, input fractional bits
- NB_DATA_OUT, 16, output word width per channel
- NBF_DATA_OUT, 15, output fractional bits
- NCH, 2, number of channels carried in parallel
- NB_CNT, 16, saturation event counter width
- Legal parameter sets: D = NBF_DATA_IN − NBF_DATA_OUT ≥ 2; NBI_OUT = NB_DATA_OUT − NBF_DATA_OUT ≤ NBI_IN = NB_DATA_IN − NBF_DATA_IN. Other sets are illegal and must be flagged at elaboration.
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high, i_rst.
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_data  in  NCH·NB_DATA_IN  packed signed samples; channel k at [k·NB_DATA_IN +: NB_DATA_IN]
- i_valid  in  1  i_data and i_mode valid
- o_in_ready  out  1  block accepts a beat this cycle
- i_mode  in  2  rounding mode: 00 truncate (floor), 01 round-half-up, 10 round-to-nearest-even, 11 truncate
- i_ready  in  1  downstream accepts o_data
- i_clr_sat  in  1  synchronous clear of o_sat_sticky and o_sat_cnt
- o_data  out  NCH·NB_DATA_OUT  packed signed results, same channel packing as i_data
- o_valid  out  1  o_data valid
- o_sat_flag  out  NCH  per-channel saturation flag, aligned with o_data
- o_sat_sticky  out  NCH  per-channel sticky saturation flag
- o_sat_cnt  out  NB_CNT  number of accepted output beats in which any channel saturated; saturates at 2^NB_CNT − 1

## Operation
- Stage 1 (round), per channel:
  - Sign-extend the input to NB_DATA_IN+1 bits, so the rounding increment can never wrap.
  - Let f = ext >>> D (floor), h = ext[D−1], s = |ext[D−2:0], l = ext[D].
  - Truncate: r = f.
  - Half-up: r = f + h.
  - RNE: r = f + (h & (s | l)).
  - r is NB_DATA_IN+1−D bits wide.
  - The mode is captured with the beat, so a mode change never affects beats already in flight.
- Stage 2 (saturate), per channel:
  - MAX = +(2^(NB_DATA_OUT−1) − 1), MIN = −2^(NB_DATA_OUT−1).
  - r > MAX gives o_data = MAX with flag = 1.
  - r < MIN gives o_data = MIN with flag = 1.
  - Otherwise o_data = r[NB_DATA_OUT−1:0] with flag = 0.
  - Saturation direction comes from the sign of r.
- Stall rule (global enable): adv = ~o_valid | i_ready, and o_in_ready = adv.
  - When adv = 1, both stages shift: stage-1 valid takes i_valid, and o_valid takes the stage-1 valid.
  - When adv = 0, all pipeline registers hold.
  - Bubbles between stages are not compressed.
- Statistics, updated on an output handshake (o_valid & i_ready):
  - o_sat_sticky |= o_sat_flag.
  - o_sat_cnt increments when |o_sat_flag and it is below its maximum.
- i_clr_sat:
  - Zeroes o_sat_sticky and o_sat_cnt next cycle.
  - Clear wins over a coincident handshake; that beat's saturation is not recorded.

## Timing
- Latency: 2 cycles from input handshake to o_valid, with no stalls. Throughput is 1 beat/cycle.
- o_data, o_sat_flag and o_valid are registered. o_in_ready is combinational from o_valid and i_ready.
- Under stall, o_data and o_sat_flag are stable while o_valid = 1 and i_ready = 0.
- Reset values: all pipeline registers, o_valid, o_data, o_sat_flag, o_sat_sticky and o_sat_cnt are 0.
- Reset mid-operation discards in-flight beats. o_in_ready = 1 in the first cycle after reset.
- o_sat_cnt at its maximum holds; it never wraps.

## Structure
- Shared package sat_round_pkg:
  - Mode constants RND_TRUNC = 2'b00, RND_HALF_UP = 2'b01, RND_RNE = 2'b10.
  - Helpers for the MAX/MIN constants.
- One sub-module, sat_round_lane:
  - Combinational round and saturate function for a single channel.
  - Instantiated NCH times per stage (round part in stage 1, saturate part in stage 2), or split into two lane functions.
- Top level holds the pipeline registers, handshake and statistics.

## Test plan
Bench parameters: NB_DATA_IN = 8, NBF_DATA_IN = 4, NB_DATA_OUT = 4, NBF_DATA_OUT = 2, NCH = 2, NB_CNT = 2.
- Mode sweep, i_data ch0 = 8'h0A (0.625):
  - Truncate → 4'h2; half-up → 4'h3; RNE → 4'h2; mode 11 → 4'h2.
  - All with flag = 0 and o_valid two cycles after input.
- RNE ties:
  - 8'h0E → 4'h4.
  - 8'hF6 → 4'hE in RNE and half-up, 4'hD in truncate.
- Saturation:
  - 8'h7F → 4'h7, flag = 1.
  - 8'h80 → 4'h8, flag = 1.
  - 8'h1E → 4'h7 with flag = 0 in truncate, and 4'h7 with flag = 1 in half-up (increment overflow).
- Backpressure:
  - Hold i_ready = 0 for 3 cycles with 2 beats in flight.
  - o_in_ready = 0 throughout, o_data stable, and no beat lost or duplicated after release.
- Statistics:
  - 4 saturating accepted beats → o_sat_cnt = 3 (held), sticky = 2'b01.
  - i_clr_sat coincident with a saturating handshake → o_sat_cnt = 0, sticky = 0.
- Reset with valid beats in both stages → o_valid = 0 immediately and all outputs 0; the next accepted beat emerges after exactly 2 cycles.
